// File: rtl/user_priority_arbiter.sv
// user_priority_arbiter
// Owner-selection stage behind the two-bit profile comparator. Holds the
// current owner's profile, presents owner/candidate profiles to the
// comparator and grants or denies takeovers, with a minimum post-grant hold
// time and a level REQ/ACK/DENY handshake toward the access front end.
//
// Ports
//   CLK, RST_N     clock (rising edge), asynchronous active-low reset
//   REQ, REQ_U     access request (level) and requesting profile
//   REL            owner release pulse
//   P_SIGNAL       comparator result: CMP_U strictly outranks CUR_U
//   CUR_U, CMP_U   owner / candidate profiles to the comparator
//   ACTIVE         an owner exists
//   ACK, DENY      handshake responses (level, cleared by REQ low)
//   PREEMPT        one-cycle pulse when a grant displaced an owner
//   BUSY           state is EVAL or HOLD
module user_priority_arbiter #(
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       REQ,
    input  logic [1:0] REQ_U,
    input  logic       REL,
    input  logic       P_SIGNAL,
    output logic [1:0] CUR_U,
    output logic [1:0] CMP_U,
    output logic       ACTIVE,
    output logic       ACK,
    output logic       DENY,
    output logic       PREEMPT,
    output logic       BUSY
);

    localparam int unsigned TW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        EVAL  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // With no hold time a grant lands directly in OWNED.
    localparam state_t GRANT_STATE = (HOLD_CYCLES == 0) ? OWNED : HOLD;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [1:0]    cur_n, cmp_n;
    logic          active_n, ack_n, deny_n, preempt_n, busy_n;
    logic          accept;

    // State and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            timer   <= '0;
            CUR_U   <= 2'b00;
            CMP_U   <= 2'b00;
            ACTIVE  <= 1'b0;
            ACK     <= 1'b0;
            DENY    <= 1'b0;
            PREEMPT <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            CUR_U   <= cur_n;
            CMP_U   <= cmp_n;
            ACTIVE  <= active_n;
            ACK     <= ack_n;
            DENY    <= deny_n;
            PREEMPT <= preempt_n;
            BUSY    <= busy_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        cur_n     = CUR_U;
        cmp_n     = CMP_U;
        active_n  = ACTIVE;
        // Handshake flags hold while REQ is high and drop once it is low.
        ack_n     = ACK && REQ;
        deny_n    = DENY && REQ;
        preempt_n = 1'b0;
        accept    = REQ && !ACK && !DENY;

        case (state)
            IDLE: begin
                if (accept) begin
                    cur_n    = REQ_U;
                    active_n = 1'b1;
                    ack_n    = 1'b1;
                    timer_n  = HOLD_LOAD;
                    state_n  = GRANT_STATE;
                end
            end
            OWNED: begin
                if (REL) begin
                    cur_n    = 2'b00;
                    active_n = 1'b0;
                    state_n  = IDLE;
                end else if (accept) begin
                    cmp_n   = REQ_U;
                    state_n = EVAL;
                end
            end
            EVAL: begin
                // A release during evaluation hands over without a preemption.
                if (REL || P_SIGNAL) begin
                    cur_n     = CMP_U;
                    ack_n     = 1'b1;
                    deny_n    = 1'b0;
                    preempt_n = !REL;
                    timer_n   = HOLD_LOAD;
                    state_n   = GRANT_STATE;
                end else begin
                    deny_n  = 1'b1;
                    ack_n   = 1'b0;
                    state_n = OWNED;
                end
            end
            HOLD: begin
                if (REL) begin
                    cur_n    = 2'b00;
                    active_n = 1'b0;
                    timer_n  = '0;
                    state_n  = IDLE;
                end else begin
                    timer_n = timer - TW'(1);
                    if (timer == TW'(1)) begin
                        state_n = OWNED;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n == EVAL) || (state_n == HOLD);
    end

endmodule

// File: tb/tb_user_priority_arbiter.sv
// Bench for user_priority_arbiter: cycle vector table through a scoreboard
// queue, plus a hand-written asynchronous-reset-during-EVAL sequence.
module tb_user_priority_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic [1:0] req_u;
    logic       rel;
    logic       p_signal;
    logic [1:0] cur_u;
    logic [1:0] cmp_u;
    logic       active;
    logic       ack;
    logic       deny;
    logic       preempt;
    logic       busy;

    int total = 0;
    int bad   = 0;

    user_priority_arbiter #(.HOLD_CYCLES(8)) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .REQ      (req),
        .REQ_U    (req_u),
        .REL      (rel),
        .P_SIGNAL (p_signal),
        .CUR_U    (cur_u),
        .CMP_U    (cmp_u),
        .ACTIVE   (active),
        .ACK      (ack),
        .DENY     (deny),
        .PREEMPT  (preempt),
        .BUSY     (busy)
    );

    // Comparator model: higher numeric profile outranks.
    assign p_signal = (cmp_u > cur_u);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp = {cur_u, cmp_u, active, ack, deny, preempt, busy}
    typedef struct packed {
        logic       req;
        logic [1:0] req_u;
        logic       rel;
        logic [8:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [8:0] exp_q[$];

    function automatic logic [8:0] outs();
        return {cur_u, cmp_u, active, ack, deny, preempt, busy};
    endfunction

    task automatic add(input logic rq, input logic [1:0] ru, input logic rl,
                       input logic [1:0] cu, input logic [1:0] cm, input logic ac,
                       input logic ak, input logic dn, input logic pr, input logic bs);
        vec_t v;
        v.req   = rq;
        v.req_u = ru;
        v.rel   = rl;
        v.exp   = {cu, cm, ac, ak, dn, pr, bs};
        vecs.push_back(v);
    endtask

    task automatic addn(input int n, input logic rq, input logic [1:0] ru, input logic rl,
                        input logic [1:0] cu, input logic [1:0] cm, input logic ac,
                        input logic ak, input logic dn, input logic pr, input logic bs);
        for (int i = 0; i < n; i++) add(rq, ru, rl, cu, cm, ac, ak, dn, pr, bs);
    endtask

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got {cur,cmp,act,ack,deny,pre,busy}=%b want %b", name, got, want);
        end
    endtask

    initial begin
        logic [8:0] e;
        req   = 1'b0;
        req_u = 2'b00;
        rel   = 1'b0;
        rst_n = 1'b0;

        // Build the vector table
        // Fresh grant 10 from IDLE, drop REQ, ride out HOLD
        add(1, 2'b10, 0, 2'b10, 2'b00, 1, 1, 0, 0, 1);
        addn(7, 0, 2'b00, 0, 2'b10, 2'b00, 1, 0, 0, 0, 1);
        add(0, 2'b00, 0, 2'b10, 2'b00, 1, 0, 0, 0, 0);
        add(0, 2'b00, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        // Owner 01, then contest by 11 -> preempt
        add(1, 2'b01, 0, 2'b01, 2'b00, 1, 1, 0, 0, 1);
        addn(7, 0, 2'b00, 0, 2'b01, 2'b00, 1, 0, 0, 0, 1);
        add(0, 2'b00, 0, 2'b01, 2'b00, 1, 0, 0, 0, 0);
        add(1, 2'b11, 0, 2'b01, 2'b11, 1, 0, 0, 0, 1);
        add(1, 2'b11, 0, 2'b11, 2'b11, 1, 1, 0, 1, 1);
        addn(7, 0, 2'b00, 0, 2'b11, 2'b11, 1, 0, 0, 0, 1);
        add(0, 2'b00, 0, 2'b11, 2'b11, 1, 0, 0, 0, 0);
        // Owner 10 contested by equal profile -> DENY
        add(0, 2'b00, 1, 2'b00, 2'b11, 0, 0, 0, 0, 0);
        add(1, 2'b10, 0, 2'b10, 2'b11, 1, 1, 0, 0, 1);
        addn(7, 0, 2'b00, 0, 2'b10, 2'b11, 1, 0, 0, 0, 1);
        add(0, 2'b00, 0, 2'b10, 2'b11, 1, 0, 0, 0, 0);
        add(1, 2'b10, 0, 2'b10, 2'b10, 1, 0, 0, 0, 1);
        add(1, 2'b10, 0, 2'b10, 2'b10, 1, 0, 1, 0, 0);
        add(1, 2'b10, 0, 2'b10, 2'b10, 1, 0, 1, 0, 0);
        add(0, 2'b00, 0, 2'b10, 2'b10, 1, 0, 0, 0, 0);
        // Owner 00 in HOLD, REQ 11 raised on HOLD cycle 2 waits for OWNED
        add(0, 2'b00, 1, 2'b00, 2'b10, 0, 0, 0, 0, 0);
        add(1, 2'b00, 0, 2'b00, 2'b10, 1, 1, 0, 0, 1);
        add(0, 2'b00, 0, 2'b00, 2'b10, 1, 0, 0, 0, 1);
        addn(6, 1, 2'b11, 0, 2'b00, 2'b10, 1, 0, 0, 0, 1);
        add(1, 2'b11, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0);
        add(1, 2'b11, 0, 2'b00, 2'b11, 1, 0, 0, 0, 1);
        add(1, 2'b11, 0, 2'b11, 2'b11, 1, 1, 0, 1, 1);
        addn(7, 0, 2'b00, 0, 2'b11, 2'b11, 1, 0, 0, 0, 1);
        add(0, 2'b00, 0, 2'b11, 2'b11, 1, 0, 0, 0, 0);
        // REL + REQ together in OWNED: release first, grant next edge
        add(1, 2'b01, 1, 2'b00, 2'b11, 0, 0, 0, 0, 0);
        add(1, 2'b01, 0, 2'b01, 2'b11, 1, 1, 0, 0, 1);
        add(0, 2'b00, 0, 2'b01, 2'b11, 1, 0, 0, 0, 1);
        // REL during HOLD returns to IDLE
        add(0, 2'b00, 1, 2'b00, 2'b11, 0, 0, 0, 0, 0);
        // REL during EVAL: unconditional handover, no preempt
        add(1, 2'b11, 0, 2'b11, 2'b11, 1, 1, 0, 0, 1);
        addn(7, 0, 2'b00, 0, 2'b11, 2'b11, 1, 0, 0, 0, 1);
        add(0, 2'b00, 0, 2'b11, 2'b11, 1, 0, 0, 0, 0);
        add(1, 2'b00, 0, 2'b11, 2'b00, 1, 0, 0, 0, 1);
        add(1, 2'b00, 1, 2'b00, 2'b00, 1, 1, 0, 0, 1);
        addn(7, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0, 0, 1);
        add(0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset", outs(), 9'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Apply vectors through the scoreboard
        for (int i = 0; i < vecs.size(); i++) begin
            string nm;
            @(negedge clk);
            req   = vecs[i].req;
            req_u = vecs[i].req_u;
            rel   = vecs[i].rel;
            exp_q.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            e  = exp_q.pop_front();
            nm = $sformatf("vec%0d", i);
            check(nm, outs(), e);
        end

        // Asynchronous reset during EVAL with REQ held high
        @(negedge clk);
        req   = 1'b1;
        req_u = 2'b10;
        rel   = 1'b0;
        @(posedge clk);
        #1;
        check("eval_before_rst", outs(), {2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", outs(), 9'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("grant_after_rst", outs(), {2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #1;
        check("ack_clear_after_rst", outs(), {2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
